// File: rtl/fu_wb_arbiter.sv
// Round-robin writeback arbiter: one holding slot per functional unit,
// fair selection into a registered output stage with valid/ready handshake.
module fu_wb_arbiter #(
    parameter int unsigned NUM_FU        = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ROB_SIZE      = 4,
    parameter int unsigned DEST_REG_SIZE = 3,
    parameter int unsigned CTRL_WIDTH    = 6
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_done,
    input  logic [NUM_FU*DATA_WIDTH-1:0]      fu_result,
    input  logic [NUM_FU*ROB_SIZE-1:0]        fu_rob_entry,
    input  logic [NUM_FU*DEST_REG_SIZE-1:0]   fu_dest_reg,
    input  logic [NUM_FU*CTRL_WIDTH-1:0]      fu_ctrl,
    output logic [NUM_FU-1:0]                 fu_free,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_result,
    output logic [ROB_SIZE-1:0]               out_rob_entry,
    output logic [DEST_REG_SIZE-1:0]          out_dest_reg,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic [2:0]                        out_fu_id,
    output logic                              err_overflow
);

    localparam int unsigned IDW = 3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    result;
        logic [ROB_SIZE-1:0]      rob;
        logic [DEST_REG_SIZE-1:0] dest;
        logic [CTRL_WIDTH-1:0]    ctrl;
    } wb_t;

    wb_t               slot_q [NUM_FU];
    wb_t               slot_d [NUM_FU];
    logic [NUM_FU-1:0] slot_valid_q, slot_valid_d;
    wb_t               out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [IDW-1:0]    out_fu_id_q, out_fu_id_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              err_q, err_d;

    logic              load_en;
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;

    // Round-robin search starting just after the last granted slot.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NUM_FU; k++) begin
            idx = (32'(ptr_q) + k) % NUM_FU;
            if (!grant_found && slot_valid_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(idx);
            end
        end
    end

    // Slot capture, output loading, pointer update and flush squash.
    always_comb begin
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_fu_id_d  = out_fu_id_q;
        ptr_d        = ptr_q;
        err_d        = err_q;
        load_en      = !out_valid_q || out_ready;

        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fu_done[i]) begin
                if (!slot_valid_q[i]) begin
                    slot_valid_d[i]  = 1'b1;
                    slot_d[i].result = fu_result[i*DATA_WIDTH +: DATA_WIDTH];
                    slot_d[i].rob    = fu_rob_entry[i*ROB_SIZE +: ROB_SIZE];
                    slot_d[i].dest   = fu_dest_reg[i*DEST_REG_SIZE +: DEST_REG_SIZE];
                    slot_d[i].ctrl   = fu_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // A granted slot was valid, so it never collides with a capture above.
        if (load_en) begin
            if (grant_found) begin
                out_d                   = slot_q[grant_idx];
                out_valid_d             = 1'b1;
                out_fu_id_d             = grant_idx;
                slot_valid_d[grant_idx] = 1'b0;
                ptr_d                   = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (flush) begin
            slot_d       = slot_q;
            slot_valid_d = '0;
            out_d        = out_q;
            out_valid_d  = 1'b0;
            out_fu_id_d  = out_fu_id_q;
            ptr_d        = IDW'(NUM_FU - 1);
            err_d        = err_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_FU; i++) slot_q[i] <= '0;
            slot_valid_q <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            out_fu_id_q  <= '0;
            ptr_q        <= IDW'(NUM_FU - 1);
            err_q        <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_fu_id_q  <= out_fu_id_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
        end
    end

    assign fu_free       = ~slot_valid_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_q.result;
    assign out_rob_entry = out_q.rob;
    assign out_dest_reg  = out_q.dest;
    assign out_ctrl      = out_q.ctrl;
    assign out_fu_id     = out_fu_id_q;
    assign err_overflow  = err_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter: table of per-cycle vectors plus
// hand-written sequences for backpressure, rotation, overflow and flush.
module tb_fu_wb_arbiter;

    localparam int NF = 5;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int DRW = 3;
    localparam int CW = 6;

    logic                clk = 1'b0;
    logic                reset, flush, out_ready;
    logic [NF-1:0]       fu_done;
    logic [NF*DW-1:0]    fu_result;
    logic [NF*RW-1:0]    fu_rob_entry;
    logic [NF*DRW-1:0]   fu_dest_reg;
    logic [NF*CW-1:0]    fu_ctrl;
    logic [NF-1:0]       fu_free;
    logic                out_valid;
    logic [DW-1:0]       out_result;
    logic [RW-1:0]       out_rob_entry;
    logic [DRW-1:0]      out_dest_reg;
    logic [CW-1:0]       out_ctrl;
    logic [2:0]          out_fu_id;
    logic                err_overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fu_wb_arbiter #(
        .NUM_FU(NF), .DATA_WIDTH(DW), .ROB_SIZE(RW),
        .DEST_REG_SIZE(DRW), .CTRL_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .fu_done(fu_done),
        .fu_result(fu_result), .fu_rob_entry(fu_rob_entry),
        .fu_dest_reg(fu_dest_reg), .fu_ctrl(fu_ctrl), .fu_free(fu_free),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rob_entry(out_rob_entry), .out_dest_reg(out_dest_reg),
        .out_ctrl(out_ctrl), .out_fu_id(out_fu_id), .err_overflow(err_overflow)
    );

    typedef struct {
        logic [NF-1:0] done;
        logic          ready;
        logic          exp_valid;
        logic [2:0]    exp_id;
        logic [NF-1:0] exp_free;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] def_res(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [RW-1:0] def_rob(input int i);
        return RW'(i + 8);
    endfunction

    task automatic set_unit(input int i, input logic [DW-1:0] r, input logic [RW-1:0] rb,
                            input logic [DRW-1:0] d, input logic [CW-1:0] c);
        fu_result[i*DW +: DW]     = r;
        fu_rob_entry[i*RW +: RW]  = rb;
        fu_dest_reg[i*DRW +: DRW] = d;
        fu_ctrl[i*CW +: CW]       = c;
    endtask

    task automatic set_default(input int i);
        set_unit(i, def_res(i), def_rob(i), DRW'(i), CW'(i * 3 + 1));
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; fu_done = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int got [$];
        int exp_rot [3];
        int seen_valid;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; fu_done = '0;
        fu_result = '0; fu_rob_entry = '0; fu_dest_reg = '0; fu_ctrl = '0;
        for (int i = 0; i < NF; i++) set_default(i);

        // Reset state
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_rob", 64'(out_rob_entry), 64'd0);
        chk("rst_id", 64'(out_fu_id), 64'd0);
        chk("rst_free", 64'(fu_free), 64'h1f);
        chk("rst_err", 64'(err_overflow), 64'd0);

        // Single result latency
        set_unit(2, 32'hDEADBEEF, 4'h5, 3'd3, 6'h2A);
        out_ready = 1'b1; fu_done = 5'b00100;
        step(); fu_done = '0;
        chk("single_free_n1", 64'(fu_free), 64'h1b);
        chk("single_valid_n1", 64'(out_valid), 64'd0);
        step();
        chk("single_valid_n2", 64'(out_valid), 64'd1);
        chk("single_result", 64'(out_result), 64'hDEADBEEF);
        chk("single_rob", 64'(out_rob_entry), 64'h5);
        chk("single_dest", 64'(out_dest_reg), 64'd3);
        chk("single_ctrl", 64'(out_ctrl), 64'h2A);
        chk("single_id", 64'(out_fu_id), 64'd2);
        chk("single_free_n2", 64'(fu_free), 64'h1f);
        step();
        chk("single_valid_n3", 64'(out_valid), 64'd0);
        set_default(2);

        // Simultaneous completion: table of per-cycle vectors
        tbl[0] = '{5'b11111, 1'b1, 1'b0, 3'd0, 5'b00000};
        tbl[1] = '{5'b00000, 1'b1, 1'b1, 3'd0, 5'b00001};
        tbl[2] = '{5'b00000, 1'b1, 1'b1, 3'd1, 5'b00011};
        tbl[3] = '{5'b00000, 1'b1, 1'b1, 3'd2, 5'b00111};
        tbl[4] = '{5'b00000, 1'b1, 1'b1, 3'd3, 5'b01111};
        tbl[5] = '{5'b00000, 1'b1, 1'b1, 3'd4, 5'b11111};
        tbl[6] = '{5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111};
        do_reset();
        for (int v = 0; v < 7; v++) begin
            fu_done = tbl[v].done; out_ready = tbl[v].ready;
            step();
            chk($sformatf("sim%0d_valid", v), 64'(out_valid), 64'(tbl[v].exp_valid));
            chk($sformatf("sim%0d_free", v), 64'(fu_free), 64'(tbl[v].exp_free));
            if (tbl[v].exp_valid) begin
                chk($sformatf("sim%0d_id", v), 64'(out_fu_id), 64'(tbl[v].exp_id));
                chk($sformatf("sim%0d_result", v), 64'(out_result), 64'(def_res(int'(tbl[v].exp_id))));
                chk($sformatf("sim%0d_rob", v), 64'(out_rob_entry), 64'(def_rob(int'(tbl[v].exp_id))));
            end
        end
        fu_done = '0;

        // Backpressure: unit 1 held, unit 3 waits in its slot
        do_reset();
        out_ready = 1'b0; fu_done = 5'b01010;
        step(); fu_done = '0;
        chk("bp_free_cap", 64'(fu_free), 64'h15);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_id", 64'(out_fu_id), 64'd1);
            chk("bp_result", 64'(out_result), 64'(def_res(1)));
            chk("bp_free3", 64'(fu_free[3]), 64'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_id", 64'(out_fu_id), 64'd3);
        step();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Round-robin rotation: unit 0 keeps re-requesting while unit 4 pends
        do_reset();
        out_ready = 1'b1; fu_done = 5'b10001;
        step();
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            fu_done = {4'b0000, fu_free[0]};
            step();
            if (out_valid) got.push_back(int'(out_fu_id));
        end
        fu_done = '0;
        exp_rot = '{0, 4, 0};
        chk("rot_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < got.size(); k++)
            chk($sformatf("rot_id%0d", k), 64'(got[k]), 64'(exp_rot[k]));
        step(); step();

        // Overflow: second completion to a full slot is dropped
        do_reset();
        out_ready = 1'b0;
        set_unit(1, 32'h11, 4'h1, 3'd1, 6'h01);
        fu_done = 5'b00010;
        step();
        chk("ovf_free", 64'(fu_free), 64'h1d);
        chk("ovf_err_pre", 64'(err_overflow), 64'd0);
        set_unit(1, 32'h22, 4'h2, 3'd2, 6'h02);
        step(); fu_done = '0;
        chk("ovf_err", 64'(err_overflow), 64'd1);
        chk("ovf_valid", 64'(out_valid), 64'd1);
        chk("ovf_result", 64'(out_result), 64'h11);
        step(); step();
        chk("ovf_err_sticky", 64'(err_overflow), 64'd1);
        chk("ovf_result_hold", 64'(out_result), 64'h11);
        out_ready = 1'b1;
        step();
        chk("ovf_no_second", 64'(out_valid), 64'd0);
        chk("ovf_err_after", 64'(err_overflow), 64'd1);
        set_default(1);

        // Flush mid-operation with slots 0,2 full and output valid
        out_ready = 1'b0; fu_done = 5'b00101;
        step(); fu_done = '0;
        step();
        chk("fl_load_id", 64'(out_fu_id), 64'd2);
        chk("fl_load_free", 64'(fu_free), 64'h1e);
        fu_done = 5'b00100;
        step(); fu_done = '0;
        chk("fl_pre_free", 64'(fu_free), 64'h1a);
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        flush = 1'b1; fu_done = 5'b10000;
        step(); flush = 1'b0; fu_done = '0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_free", 64'(fu_free), 64'h1f);
        chk("fl_err_kept", 64'(err_overflow), 64'd1);
        out_ready = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_valid) seen_valid++;
        end
        chk("fl_no_unit4", 64'(seen_valid), 64'd0);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("fl_rst_err", 64'(err_overflow), 64'd0);
        chk("fl_rst_result", 64'(out_result), 64'd0);
        chk("fl_rst_id", 64'(out_fu_id), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Round-robin writeback arbiter that shares the single execution-stage result bus among the functional units (simple ALU, FP ALU, complex ALU, predicate ALU, load/store queue). Each unit deposits its completed result into a dedicated one-entry holding slot; the arbiter selects one slot per cycle into a registered output stage that drives the ROB/result bus under a valid/ready handshake. It replaces fixed-priority result selection with fair, starvation-free selection and explicit backpressure to the units.

## Interface
- NUM_FU, 5, number of functional units (index width 3 bits, NUM_FU ≤ 8)
- DATA_WIDTH, 32, result width
- ROB_SIZE, 4, ROB entry tag width
- DEST_REG_SIZE, 3, destination register tag width
- CTRL_WIDTH, 6, control-signal passthrough width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous squash of all slots and output stage
- fu_done  in  NUM_FU  per-unit completion strobe, one cycle per result
- fu_result  in  NUM_FU*DATA_WIDTH  packed results, unit i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- fu_rob_entry  in  NUM_FU*ROB_SIZE  packed ROB tags
- fu_dest_reg  in  NUM_FU*DEST_REG_SIZE  packed destination tags
- fu_ctrl  in  NUM_FU*CTRL_WIDTH  packed control signals
- fu_free  out  NUM_FU  slot i empty; unit i may assert fu_done[i]
- out_valid  out  1  output stage holds a result
- out_ready  in  1  consumer accepts the result this cycle
- out_result / out_rob_entry / out_dest_reg / out_ctrl  out  DATA_WIDTH / ROB_SIZE / DEST_REG_SIZE / CTRL_WIDTH  selected result fields
- out_fu_id  out  3  index of unit that produced the output
- err_overflow  out  1  sticky: fu_done arrived at a full slot

## Operation
- Slots: per unit, slot_valid plus stored fields. fu_free[i] = ~slot_valid[i] (pure state, no combinational path from out_ready).
- Capture: fu_done[i] && !slot_valid[i] → store fields, slot_valid[i]=1 next cycle.
- Overflow: fu_done[i] && slot_valid[i] → new data dropped, slot keeps old data, err_overflow set (cleared only by reset).
- Output load condition: load_en = !out_valid || out_ready.
- Arbitration: when load_en and any slot_valid, search slots starting at (ptr+1) mod NUM_FU, wrapping; first valid slot g wins. Output stage loads slot g fields, out_fu_id=g, out_valid=1; slot_valid[g] cleared; ptr=g.
- load_en and no slot valid → out_valid=0 next cycle (fields hold last value).
- !load_en → output stage and all slots hold (except new captures into empty slots).
- A slot cleared this edge cannot capture on the same edge (fu_free was 0); it is capturable the following cycle.
- Flush: all slot_valid=0, out_valid=0, ptr=NUM_FU-1 next cycle; fu_done in the flush cycle is discarded; err_overflow unaffected.
- Reset: same as flush plus err_overflow=0 and all output fields 0.

## Timing
- Reset values: out_valid=0, out_result=0, out_rob_entry=0, out_dest_reg=0, out_ctrl=0, out_fu_id=0, fu_free=all 1, err_overflow=0, ptr=NUM_FU-1 (unit 0 highest priority first).
- Latency: fu_done[i] in cycle N, empty output stage, no competitors → out_valid=1 with that result in cycle N+2; fu_free[i] low in N+1, high again in N+2.
- Throughput: one result per cycle while out_ready held high and slots nonempty.
- Handshake: transfer occurs on a cycle with out_valid && out_ready; output fields stable while out_valid && !out_ready.
- Fairness: a valid slot is granted within NUM_FU consecutive loads.
- reset has priority over flush; flush has priority over capture and arbitration.

## Test plan
- Single result: after reset, fu_done[2] with result 0xDEADBEEF, rob 0x5, dest 3, out_ready=1 → cycle N+2 out_valid=1, out_result=0xDEADBEEF, out_rob_entry=0x5, out_dest_reg=3, out_fu_id=2; cycle N+3 out_valid=0.
- Simultaneous: all five fu_done in one cycle, out_ready=1 → out_fu_id sequence 0,1,2,3,4 on consecutive cycles; fu_free[i] returns high the cycle after unit i is loaded.
- Backpressure: out_ready=0 with units 1 and 3 done → out_fu_id=1 held stable for 4 cycles, slot 3 fu_free=0; raise out_ready → fu_id 3 next cycle.
- Round-robin rotation: unit 0 re-asserts fu_done every time fu_free[0] rises while unit 4 is pending → unit 4 granted before unit 0's second grant.
- Overflow: out_ready=0, fu_done[1] twice (values 0x11, 0x22) → err_overflow=1 and stays; after out_ready=1 output shows 0x11 only.
- Flush/reset mid-operation: slots 0,2 full and out_valid=1, assert flush with fu_done[4] same cycle → next cycle out_valid=0, fu_free=all 1, unit 4 result never appears; reset then clears err_overflow.
